// File: rtl/noc_link_pipe_if.sv
// Flit link handshake bundle: valid/flit travel downstream, ready/vc_ready travel upstream.
// The link consumes one bundle as slave (rx side) and drives one as master (tx side).
interface noc_link_pipe_if #(
  parameter int FLIT_WIDTH = 64,
  parameter int VC_NUM     = 2
);
  logic                  valid;
  logic                  ready;
  logic [FLIT_WIDTH-1:0] flit;
  logic [VC_NUM-1:0]     vc_ready;

  modport master (output valid, output flit, input ready, input vc_ready);
  modport slave  (input valid, input flit, output ready, output vc_ready);
endinterface

// File: rtl/noc_link_pipe.sv
// NoC link pipeline: STAGES two-entry elastic stages plus a STAGES-deep per-VC ready delay line.
// Optional macro NOC_LINK_STATS_EN adds saturating tx transfer / stall counters.
module noc_link_pipe #(
  parameter int FLIT_WIDTH = 64,
  parameter int VC_NUM     = 2,
  parameter int STAGES     = 2
) (
  input  logic            noc_clk,
  input  logic            noc_rst,
  noc_link_pipe_if.slave  rx,
  noc_link_pipe_if.master tx
`ifdef NOC_LINK_STATS_EN
  ,
  output logic [31:0]     stat_flit_cnt,
  output logic [31:0]     stat_stall_cnt
`endif
);

  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("noc_link_pipe: STAGES=%0d outside legal range 1..8", STAGES);
  end
  if (VC_NUM < 1 || VC_NUM > 8) begin : g_bad_vc_num
    $error("noc_link_pipe: VC_NUM=%0d outside legal range 1..8", VC_NUM);
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } stage_e;

  // Chain index s is the input of stage s; index STAGES is the link output.
  logic [STAGES:0]                 vld;
  logic [STAGES:0]                 rdy;
  logic [STAGES:0][FLIT_WIDTH-1:0] dat;
  logic                            tx_vld;

  assign vld[0]      = rx.valid;
  assign dat[0]      = rx.flit;
  assign rx.ready    = rdy[0];
  assign rdy[STAGES] = tx.ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_e                state_q, state_d;
    logic                  ready_q;
    logic [FLIT_WIDTH-1:0] head_q, head_d;
    logic [FLIT_WIDTH-1:0] skid_q, skid_d;
    logic                  out_vld;
    logic                  push;
    logic                  pop;

    assign out_vld  = (state_q != EMPTY);
    assign push     = vld[s] & ready_q;
    assign pop      = out_vld & rdy[s+1];
    assign rdy[s]   = ready_q;
    assign vld[s+1] = out_vld;
    assign dat[s+1] = head_q;

    always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = HALF;
            head_d  = dat[s];
          end
        end
        HALF: begin
          if (push && pop) begin
            head_d = dat[s];
          end else if (push) begin
            state_d = FULL;
            skid_d  = dat[s];
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // ready_q is low here, so only a pop can happen
          if (pop) begin
            state_d = HALF;
            head_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    always_ff @(posedge noc_clk) begin
      if (noc_rst) begin
        state_q <= EMPTY;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != FULL);
      end
    end

    always_ff @(posedge noc_clk) begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Masking with reset keeps a discarded flit from handshaking in the reset cycle.
  assign tx_vld   = vld[STAGES] & ~noc_rst;
  assign tx.valid = tx_vld;
  assign tx.flit  = dat[STAGES];

  logic [STAGES-1:0][VC_NUM-1:0] vc_q;

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      vc_q <= '0;
    end else begin
      vc_q[0] <= tx.vc_ready;
      for (int i = 1; i < STAGES; i++) begin
        vc_q[i] <= vc_q[i-1];
      end
    end
  end

  assign rx.vc_ready = vc_q[STAGES-1];

`ifdef NOC_LINK_STATS_EN
  logic [31:0] stat_flit_cnt_q;
  logic [31:0] stat_stall_cnt_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      stat_flit_cnt_q  <= '0;
      stat_stall_cnt_q <= '0;
    end else begin
      if (tx_vld && tx.ready) begin
        stat_flit_cnt_q <= sat_inc(stat_flit_cnt_q);
      end
      if (tx_vld && !tx.ready) begin
        stat_stall_cnt_q <= sat_inc(stat_stall_cnt_q);
      end
    end
  end

  assign stat_flit_cnt  = stat_flit_cnt_q;
  assign stat_stall_cnt = stat_stall_cnt_q;
`endif

endmodule
